// File: rtl/mul3_rr_sched.sv
// mul3_rr_sched: round-robin sharing of one pipelined a*b*c multiplier among
// N requesters. Issued products are tracked by an ID tag pipeline aligned to the
// multiplier latency and returned tagged with the owning requester.
module mul3_rr_sched #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2,
   parameter int unsigned AW  = 18,
   parameter int unsigned BW  = 10,
   parameter int unsigned CW  = 10,
   parameter int unsigned LAT = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        en_i,
   input  logic [N-1:0]                req_valid_i,
   output logic [N-1:0]                req_ready_o,
   input  logic [N*AW-1:0]             req_a_i,
   input  logic [N*BW-1:0]             req_b_i,
   input  logic [N*CW-1:0]             req_c_i,
   output logic [AW-1:0]               mul_a_o,
   output logic [BW-1:0]               mul_b_o,
   output logic [CW-1:0]               mul_c_o,
   input  logic [AW+BW+CW-1:0]         mul_result_i,
   output logic                        rsp_valid_o,
   output logic [IDW-1:0]              rsp_id_o,
   output logic [AW+BW+CW-1:0]         rsp_data_o,
   output logic [$clog2(LAT+2)-1:0]    inflight_o,
   output logic                        idle_o
);

   localparam int unsigned PW  = AW + BW + CW;
   localparam int unsigned IFW = $clog2(LAT + 2);

   logic [N-1:0]   act_req;
   logic           hs;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] idx;
   logic [IDW-1:0] ptr_q, ptr_d;

   logic [AW-1:0]  mul_a_q, mul_a_d;
   logic [BW-1:0]  mul_b_q, mul_b_d;
   logic [CW-1:0]  mul_c_q, mul_c_d;

   logic           tag_v_q  [LAT+1];
   logic [IDW-1:0] tag_id_q [LAT+1];

   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic [PW-1:0]  rsp_data_q;

   logic [IFW-1:0] inflight_q, inflight_d;

   assign act_req = req_valid_i & {N{en_i}};

   // Round-robin pick: first active requester at or after ptr, wrapping.
   always_comb begin
      hs     = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = IDW'((32'(ptr_q) + k) % N);
         if (!hs && act_req[idx]) begin
            hs     = 1'b1;
            winner = idx;
         end
      end
   end

   // Grant vector, next pointer and the winner's operands.
   always_comb begin
      req_ready_o = hs ? (N'(1) << winner) : '0;
      ptr_d       = ptr_q;
      if (hs) begin
         ptr_d = (winner == IDW'(N - 1)) ? '0 : winner + IDW'(1);
      end
      mul_a_d = req_a_i[winner*AW +: AW];
      mul_b_d = req_b_i[winner*BW +: BW];
      mul_c_d = req_c_i[winner*CW +: CW];
   end

   // Pointer and operand registers update only on a handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q   <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         mul_c_q <= '0;
      end else if (hs) begin
         ptr_q   <= ptr_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         mul_c_q <= mul_c_d;
      end
   end

   // Tag pipeline: {valid, id} shifts every edge, never stalls.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i <= LAT; i++) begin
            tag_v_q[i]  <= 1'b0;
            tag_id_q[i] <= '0;
         end
      end else begin
         tag_v_q[0]  <= hs;
         tag_id_q[0] <= winner;
         for (int unsigned i = 1; i <= LAT; i++) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
      end
   end

   // Response register: capture the multiplier output when the oldest tag is valid.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= tag_v_q[LAT];
         if (tag_v_q[LAT]) begin
            rsp_id_q   <= tag_id_q[LAT];
            rsp_data_q <= mul_result_i;
         end
      end
   end

   // In-flight count: issue increments, response registration decrements.
   always_comb begin
      inflight_d = inflight_q;
      case ({hs, tag_v_q[LAT]})
         2'b10:   inflight_d = inflight_q + IFW'(1);
         2'b01:   inflight_d = inflight_q - IFW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // In-flight counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inflight_q <= '0;
      end else begin
         inflight_q <= inflight_d;
      end
   end

   assign mul_a_o     = mul_a_q;
   assign mul_b_o     = mul_b_q;
   assign mul_c_o     = mul_c_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_data_o  = rsp_data_q;
   assign inflight_o  = inflight_q;
   assign idle_o      = (inflight_q == '0);

endmodule

// File: tb/tb_mul3_rr_sched.sv
// Bench for mul3_rr_sched: behavioural 4-stage multiplier, accept monitor pushing
// expected responses into a scoreboard, response monitor popping and comparing.
module tb_mul3_rr_sched;

   localparam int unsigned N   = 4;
   localparam int unsigned AW  = 18;
   localparam int unsigned BW  = 10;
   localparam int unsigned CW  = 10;
   localparam int unsigned LAT = 4;
   localparam int unsigned PW  = AW + BW + CW;

   logic            clk;
   logic            rst;
   logic            en;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*AW-1:0] req_a;
   logic [N*BW-1:0] req_b;
   logic [N*CW-1:0] req_c;
   logic [AW-1:0]   mul_a;
   logic [BW-1:0]   mul_b;
   logic [CW-1:0]   mul_c;
   logic [PW-1:0]   mul_result;
   logic            rsp_valid;
   logic [1:0]      rsp_id;
   logic [PW-1:0]   rsp_data;
   logic [2:0]      inflight;
   logic            idle;

   int n_checks = 0;
   int n_fail   = 0;
   int run      = 0;
   int last_run = 0;

   logic [PW-1:0] exp_arr [N];
   logic [1:0]    sb_id   [$];
   logic [PW-1:0] sb_data [$];
   logic [PW-1:0] mpipe   [LAT];

   logic [PW-1:0] fair_exp [4]  = '{38'd6, 38'd12, 38'd18, 38'd24};
   logic [PW-1:0] b2b_exp  [10] = '{38'd12, 38'd24, 38'd36, 38'd48, 38'd60,
                                    38'd72, 38'd84, 38'd96, 38'd108, 38'd120};

   mul3_rr_sched #(.N(4), .IDW(2), .AW(18), .BW(10), .CW(10), .LAT(4)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .req_c_i      (req_c),
      .mul_a_o      (mul_a),
      .mul_b_o      (mul_b),
      .mul_c_o      (mul_c),
      .mul_result_i (mul_result),
      .rsp_valid_o  (rsp_valid),
      .rsp_id_o     (rsp_id),
      .rsp_data_o   (rsp_data),
      .inflight_o   (inflight),
      .idle_o       (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: no reset, so stale products stay in the pipe.
   always @(posedge clk) begin
      mpipe[0] <= PW'(mul_a) * PW'(mul_b) * PW'(mul_c);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign mul_result = mpipe[LAT-1];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_req(input int r, input logic [AW-1:0] a, input logic [BW-1:0] b,
                          input logic [CW-1:0] c, input logic [PW-1:0] e);
      req_a[r*AW +: AW] = a;
      req_b[r*BW +: BW] = b;
      req_c[r*CW +: CW] = c;
      exp_arr[r]        = e;
   endtask

   task automatic wait_idle(input string name);
      int i = 0;
      while (!idle && i < 50) begin
         @(negedge clk);
         i++;
      end
      check(name, 64'(idle), 64'd1);
      @(negedge clk);
      #2;
   endtask

   // Single request on requester r; measures negedges from drive to rsp_valid.
   task automatic issue_timed(input int r, input logic [N-1:0] exp_ready, input string name);
      int lat;
      @(negedge clk);
      req_valid = N'(1) << r;
      #1 check({name, "_grant"}, 64'(req_ready), 64'(exp_ready));
      @(negedge clk);
      req_valid = '0;
      check({name, "_inflight_issued"}, 64'(inflight), 64'd1);
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'd6);
      check({name, "_inflight_done"}, 64'(inflight), 64'd0);
      check({name, "_idle"}, 64'(idle), 64'd1);
      #2;
   endtask

   // Accept monitor: just before the edge, push the expectation for each handshake.
   always begin
      @(negedge clk);
      #4;
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb_id.push_back(2'(i));
               sb_data.push_back(exp_arr[i]);
            end
         end
      end
   end

   // Response monitor: pop and compare on each rsp_valid strobe.
   always begin
      @(negedge clk);
      if (!rst && rsp_valid) begin
         run++;
         if (sb_id.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d data %0d, required no response (t=%0t)",
                     rsp_id, rsp_data, $time);
         end else begin
            check("rsp_id", 64'(rsp_id), 64'(sb_id.pop_front()));
            check("rsp_data", 64'(rsp_data), 64'(sb_data.pop_front()));
         end
      end else if (run != 0) begin
         last_run = run;
         run      = 0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      en        = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_c     = '0;
      for (int i = 0; i < N; i++) exp_arr[i] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_mul_a", 64'(mul_a), 64'd0);
      check("rst_mul_bc", 64'({mul_b, mul_c}), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_idle", 64'(idle), 64'd1);
      rst = 1'b0;
      #1 check("rst_ready", 64'(req_ready), 64'd0);

      // Fairness: all four requesters valid, grants rotate 0,1,2,3,...
      @(negedge clk);
      for (int r = 0; r < 4; r++) set_req(r, 18'(r + 1), 10'd2, 10'd3, fair_exp[r]);
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check("fair_grant", 64'(req_ready), 64'(4'b0001 << (k % 4)));
         check("fair_inflight", 64'(inflight), 64'((k < 5) ? k : 5));
      end
      @(negedge clk);
      req_valid = '0;
      wait_idle("fair_drain");
      check("fair_run", 64'(last_run), 64'd8);

      // Single op on requester 0: 3*5*7
      set_req(0, 18'd3, 10'd5, 10'd7, 38'd105);
      issue_timed(0, 4'b0001, "single");

      // Maximum operands on requester 3 (ptr now 1, wraps forward to 3)
      set_req(3, 18'd262143, 10'd1023, 10'd1023, 38'd274340251647);
      issue_timed(3, 4'b1000, "maxop");

      // Requester 2 back-to-back for 10 cycles
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         set_req(2, 18'(k + 1), 10'd3, 10'd4, b2b_exp[k]);
         req_valid = 4'b0100;
         #1 check("b2b_grant", 64'(req_ready), 64'd4);
      end
      @(negedge clk);
      req_valid = '0;
      wait_idle("b2b_drain");
      check("b2b_run", 64'(last_run), 64'd10);

      // en low with pending requests; pointer must survive
      @(negedge clk);
      set_req(1, 18'd2, 10'd3, 10'd5, 38'd30);
      req_valid = 4'b0010;
      #1 check("en_pre_grant", 64'(req_ready), 64'd2);
      @(negedge clk);
      set_req(0, 18'd4, 10'd4, 10'd4, 38'd64);
      set_req(3, 18'd7, 10'd1, 10'd1, 38'd7);
      req_valid = 4'b1001;
      en        = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check("en_low_ready", 64'(req_ready), 64'd0);
         check("en_low_inflight", 64'(inflight), 64'd1);
      end
      @(negedge clk);
      en = 1'b1;
      #1 check("en_resume_grant", 64'(req_ready), 64'd8);
      @(negedge clk);
      req_valid = 4'b0001;
      #1 check("en_next_grant", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = '0;
      wait_idle("en_drain");

      // Reset with three ops in flight
      set_req(0, 18'd1, 10'd1, 10'd1, 38'd1);
      set_req(1, 18'd2, 10'd2, 10'd2, 38'd8);
      set_req(2, 18'd3, 10'd3, 10'd3, 38'd27);
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         req_valid = N'(1) << r;
      end
      @(negedge clk);
      req_valid = '0;
      check("pre_rst_inflight", 64'(inflight), 64'd3);
      rst = 1'b1;
      sb_id.delete();
      sb_data.delete();
      #1;
      check("mid_rst_inflight", 64'(inflight), 64'd0);
      check("mid_rst_idle", 64'(idle), 64'd1);
      check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_mul_a", 64'(mul_a), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("post_rst_quiet", 64'(rsp_valid), 64'd0);
      end
      set_req(1, 18'd100, 10'd10, 10'd10, 38'd10000);
      issue_timed(1, 4'b0010, "post_rst");

      repeat (3) @(negedge clk);
      check("sb_empty", 64'(sb_id.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mul3_rr_sched.md
# mul3_rr_sched

Round-robin scheduler that shares one pipelined 3-operand multiplier (a × b × c, 18b × 10b × 10b → 38b, fixed 4-cycle latency, no stall) among N requesters in the bicubic weight path. Requesters present operands with valid/ready handshakes; the block grants one per cycle, drives the multiplier operand registers and tracks each issued product with an ID through a shift pipeline aligned to the multiplier latency. It returns each result tagged with the owning requester.

## Interface
- N, 4: number of requesters (2..8)
- IDW, 2: requester ID width, clog2(N)
- AW / BW / CW, 18 / 10 / 10: operand widths
- LAT, 4: multiplier latency, from operand-register edge to result-valid edge
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  issue enable; low blocks new grants, in-flight ops complete
- req_valid  in  N  per-requester request
- req_ready  out  N  one-hot grant; handshake when req_valid[i] & req_ready[i]
- req_a  in  N*AW  packed, requester i at [i*AW +: AW]
- req_b  in  N*BW  packed
- req_c  in  N*CW  packed
- mul_a / mul_b / mul_c  out  AW / BW / CW  registered operands to multiplier
- mul_result  in  AW+BW+CW  multiplier output
- rsp_valid  out  1  result strobe, one cycle
- rsp_id  out  IDW  owning requester
- rsp_data  out  AW+BW+CW  product
- inflight  out  clog2(LAT+2)  ops issued and not yet returned
- idle  out  1  inflight == 0

## Operation
- Arbitration: combinational round-robin over req_valid & {N{en}}, starting at pointer ptr (reset 0). Lowest index at or above ptr wins, wrapping. req_ready is one-hot of the winner, all-zero if no request or en low.
- On handshake: ptr <= winner+1 mod N. No handshake: ptr holds.
- req_ready depends only on req_valid, en and ptr, never on operand values. A requester may drop req_valid before being granted without side effects.
- Issue edge: mul_a/b/c <= the winner's operands. Without a handshake, operand registers hold their previous value; the multiplier output is ignored via tags.
- Tag pipeline: LAT+1 stages of {v, id}. Stage 0 loads {handshake, winner}. Each edge shifts. It never stalls; no backpressure on responses.
- Response edge: when the last stage v=1, register rsp_valid<=1, rsp_id<=id, rsp_data<=mul_result. Otherwise rsp_valid<=0 and rsp_data/rsp_id hold.
- inflight: +1 on handshake, −1 on rsp_valid assertion. Both in the same cycle leave it unchanged. Max LAT+1; never over/underflows.
- Arithmetic: unsigned; rsp_data is the exact full-width product, with no truncation.
- Reset (any time, incl. mid-operation): clears all tags, ptr, operand regs, rsp_*, inflight. In-flight products are discarded. Multiplier-internal garbage after reset is never reported because the tags are 0.

## Timing
- Reset values: req_ready=0 (combinational, reflects inputs after reset release), mul_a/b/c=0, rsp_valid=0, rsp_id=0, rsp_data=0, inflight=0, idle=1.
- Handshake at edge E0 → operands visible after E0 → mul_result valid after E0+LAT → rsp_valid high the cycle after E0+LAT+1 (LAT+1 edges after accept).
- Throughput: one op per cycle sustained. Responses return in issue order.
- en falling: the handshake in the same cycle is suppressed (req_ready=0). Already-issued ops return on schedule.

## Test plan
- Single op: req 0 a=3,b=5,c=7 at E0 → rsp_valid 1 cycle after E5 (LAT=4), rsp_id=0, rsp_data=105, inflight 1→0, idle returns to 1.
- Fairness: all 4 requesters valid continuously, ptr=0 → grants 0,1,2,3,0,… every cycle. Responses are in the same order with the correct products; inflight saturates at 5.
- Max operands: a=262143, b=1023, c=1023 → rsp_data=274340251647, no truncation.
- Back-to-back distinct operands from requester 2 only for 10 cycles → 10 consecutive rsp_valid cycles, each product matching, rsp_id=2.
- en low for 3 cycles with requests pending → req_ready=0, no new tags; prior ops still return; ptr unchanged. Grants resume at ptr when en rises.
- Reset asserted with 3 ops in flight → no rsp_valid after reset; inflight=0, idle=1. A post-reset op on requester 1 returns correctly after LAT+1 edges.
